// File: rtl/mmio_timer_if.sv
// mmio_timer_if: CPU memory-bus signals seen by the memory-mapped timer.
// The CPU side drives Address/Wr/Datain; the timer returns Dataout, Hit and Irq.
interface mmio_timer_if;
    logic [31:0] Address;
    logic        Wr;
    logic [31:0] Datain;
    logic [31:0] Dataout;
    logic        Hit;
    logic        Irq;

    modport master (
        output Address, Wr, Datain,
        input  Dataout, Hit, Irq
    );

    modport slave (
        input  Address, Wr, Datain,
        output Dataout, Hit, Irq
    );
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: prescaled 32-bit up-counter with compare match, claimed as a 16-byte MMIO window.
// Define MMIO_TIMER_IRQ_EN to implement CTRL.IRQ_EN and drive Irq; otherwise Irq is tied low.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0F00,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    mmio_timer_if.slave bus
);
    // state | meaning
    // IDLE  | CTRL.EN=0: prescaler held at 0, COUNT frozen
    // RUN   | CTRL.EN=1: prescaler counts, COUNT advances on each tick
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;
    localparam logic [PRESCALE_W-1:0] PRESC_ONE = 1;

    state_t                state_q, state_d;
    logic                  auto_q, auto_d;
    logic                  irq_en_q, irq_en_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic                  match_q, match_d;
    logic [31:0]           dataout_q, dataout_d;

    logic        hit;
    logic [1:0]  sel;
    logic        wr_hit;
    logic        wr_ctrl, wr_count, wr_compare, wr_status;
    logic        tick;
    logic [31:0] count_inc;
    logic        match_evt;
    logic [31:0] ctrl_rd;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign hit        = (bus.Address[31:4] == BASE_ADDR[31:4]);
    assign sel        = bus.Address[3:2];
    assign wr_hit     = bus.Wr & hit;
    assign wr_ctrl    = wr_hit & (sel == REG_CTRL);
    assign wr_count   = wr_hit & (sel == REG_COUNT);
    assign wr_compare = wr_hit & (sel == REG_COMPARE);
    assign wr_status  = wr_hit & (sel == REG_STATUS);

    assign tick      = (state_q == RUN) && (presc_cnt_q == prescale_q);
    assign count_inc = count_q + 32'd1;
    // A CPU write to COUNT on a tick edge suppresses match evaluation for that edge.
    assign match_evt = tick && !wr_count && (count_inc == compare_q);

    assign unused_bits = ^{bus.Datain, bus.Address[1:0]};

    always_comb begin
        ctrl_rd                  = '0;
        ctrl_rd[0]               = (state_q == RUN);
        ctrl_rd[1]               = auto_q;
        ctrl_rd[2]               = irq_en_q;
        ctrl_rd[8 +: PRESCALE_W] = prescale_q;
    end

    always_comb begin
        rd_data = '0;
        unique case (sel)
            REG_CTRL:    rd_data = ctrl_rd;
            REG_COUNT:   rd_data = count_q;
            REG_COMPARE: rd_data = compare_q;
            REG_STATUS:  rd_data = {31'd0, match_q};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        auto_d      = auto_q;
        irq_en_d    = irq_en_q;
        prescale_d  = prescale_q;
        presc_cnt_d = '0;
        count_d     = count_q;
        compare_d   = compare_q;
        match_d     = match_q;
        dataout_d   = (hit && !bus.Wr) ? rd_data : '0;

        unique case (state_q)
            IDLE: presc_cnt_d = '0;
            RUN: begin
                presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_ONE;
                if (tick && !wr_count) begin
                    count_d = (match_evt && auto_q) ? '0 : count_inc;
                    if (match_evt && !auto_q) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase

        if (wr_ctrl) begin
            state_d    = bus.Datain[0] ? RUN : IDLE;
            auto_d     = bus.Datain[1];
`ifdef MMIO_TIMER_IRQ_EN
            irq_en_d   = bus.Datain[2];
`endif
            prescale_d = bus.Datain[8 +: PRESCALE_W];
        end

        if (wr_count) begin
            count_d     = bus.Datain;
            presc_cnt_d = '0;
        end

        if (wr_compare) begin
            compare_d = bus.Datain;
        end

        // W1C first, so a match on the same edge keeps MATCH set.
        if (wr_status && bus.Datain[0]) begin
            match_d = 1'b0;
        end
        if (match_evt) begin
            match_d = 1'b1;
        end

        if (state_d == IDLE) begin
            presc_cnt_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            auto_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            prescale_q  <= '0;
            presc_cnt_q <= '0;
            count_q     <= '0;
            compare_q   <= '0;
            match_q     <= 1'b0;
            dataout_q   <= '0;
        end else begin
            state_q     <= state_d;
            auto_q      <= auto_d;
            irq_en_q    <= irq_en_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            match_q     <= match_d;
            dataout_q   <= dataout_d;
        end
    end

    assign bus.Hit     = hit;
    assign bus.Dataout = dataout_q;
`ifdef MMIO_TIMER_IRQ_EN
    assign bus.Irq     = match_q & irq_en_q;
`else
    assign bus.Irq     = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed scenarios plus randomized bus traffic checked against a behavioural model.
// The model follows MMIO_TIMER_IRQ_EN the same way the design does.
module tb_mmio_timer;
    localparam logic [31:0] BASE = 32'h0000_0F00;
    localparam int PW = 8;
`ifdef MMIO_TIMER_IRQ_EN
    localparam bit IRQ_IMPL = 1'b1;
`else
    localparam bit IRQ_IMPL = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;

    mmio_timer_if bif();

    mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(PW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bif)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    bit            m_en, m_auto, m_irqen, m_match;
    logic [PW-1:0] m_presc, m_pcnt;
    logic [31:0]   m_count, m_compare, m_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_irqen = 0; m_match = 0;
        m_presc = '0; m_pcnt = '0;
        m_count = '0; m_compare = '0; m_dout = '0;
    endtask

    function automatic logic [31:0] model_reg(input logic [1:0] sel);
        case (sel)
            2'd0:    return {16'd0, m_presc, 5'd0, m_irqen, m_auto, m_en};
            2'd1:    return m_count;
            2'd2:    return m_compare;
            default: return {31'd0, m_match};
        endcase
    endfunction

    // One rising edge of the timer, applied to the model from the register-level rules.
    task automatic model_edge(input logic [31:0] a, input logic w, input logic [31:0] d);
        bit            hit, tick, matched;
        logic [1:0]    sel;
        logic [31:0]   nxt, n_count, n_compare, n_dout;
        logic [PW-1:0] n_presc, n_pcnt;
        bit            n_en, n_auto, n_irqen, n_match;
        hit = ((a >> 4) == (BASE >> 4));
        sel = a[3:2];
        n_dout = (hit && !w) ? model_reg(sel) : 32'd0;
        n_en = m_en; n_auto = m_auto; n_irqen = m_irqen; n_match = m_match;
        n_presc = m_presc; n_count = m_count; n_compare = m_compare;
        matched = 0;
        tick = m_en && (m_pcnt == m_presc);
        if (tick && !(hit && w && sel == 2'd1)) begin
            nxt = m_count + 32'd1;
            if (nxt == m_compare) begin
                matched = 1;
                n_match = 1;
                n_count = m_auto ? 32'd0 : nxt;
                if (!m_auto) n_en = 0;
            end else begin
                n_count = nxt;
            end
        end
        n_pcnt = (m_en && !tick) ? m_pcnt + 8'd1 : 8'd0;
        if (hit && w) begin
            case (sel)
                2'd0: begin
                    n_en = d[0]; n_auto = d[1]; n_irqen = IRQ_IMPL & d[2]; n_presc = d[15:8];
                end
                2'd1: begin n_count = d; n_pcnt = '0; end
                2'd2: n_compare = d;
                default: if (d[0] && !matched) n_match = 0;
            endcase
        end
        if (!n_en) n_pcnt = '0;
        m_en = n_en; m_auto = n_auto; m_irqen = n_irqen; m_match = n_match;
        m_presc = n_presc; m_pcnt = n_pcnt; m_count = n_count; m_compare = n_compare;
        m_dout = n_dout;
    endtask

    task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d, output logic [31:0] rd);
        bif.Address = a; bif.Wr = w; bif.Datain = d;
        #1;
        check("hit", {31'd0, bif.Hit}, {31'd0, ((a >> 4) == (BASE >> 4))});
        @(posedge Clk);
        model_edge(a, w, d);
        @(negedge Clk);
        check("dataout", bif.Dataout, m_dout);
        check("irq", {31'd0, bif.Irq}, {31'd0, m_match & m_irqen});
        rd = bif.Dataout;
    endtask

    task automatic wr(input int unsigned idx, input logic [31:0] d);
        logic [31:0] dummy;
        cyc(BASE + (idx << 2) + $urandom_range(0, 3), 1'b1, d, dummy);
    endtask

    task automatic rd(input int unsigned idx, output logic [31:0] v);
        cyc(BASE + (idx << 2) + $urandom_range(0, 3), 1'b0, $urandom, v);
    endtask

    task automatic idle(input int n);
        logic [31:0] dummy;
        for (int i = 0; i < n; i++) cyc(32'h0, 1'b0, 32'h0, dummy);
    endtask

    logic [31:0] v, a, d;
    logic        w;
    int unsigned op;

    initial begin
        Reset = 1'b1;
        bif.Address = '0; bif.Wr = 1'b0; bif.Datain = '0;
        model_reset();
        repeat (2) @(negedge Clk);
        check("rst_dout", bif.Dataout, 32'h0);
        check("rst_irq", {31'd0, bif.Irq}, 32'h0);
        Reset = 1'b0;

        rd(0, v); check("rst_ctrl", v, 32'h0);
        rd(1, v); check("rst_count", v, 32'h0);
        rd(2, v); check("rst_compare", v, 32'h0);
        rd(3, v); check("rst_status", v, 32'h0);
        cyc(32'h0000_0F08, 1'b1, 32'h1234, v);
        cyc(32'h0000_0F08, 1'b0, 32'h0, v); check("cmp_readback", v, 32'h1234);
        cyc(32'h0000_0F10, 1'b0, 32'h0, v); check("miss_dout", v, 32'h0);
        check("miss_hit", {31'd0, bif.Hit}, 32'h0);

        wr(1, 0); wr(0, 32'h0000_0301);
        idle(40);
        rd(1, v); check("presc_count", v, 32'd10);
        wr(0, 0);

        wr(1, 0); wr(2, 5); wr(0, 32'h1);
        idle(5);
        rd(3, v); check("oneshot_match", v, 32'h1);
        rd(1, v); check("oneshot_count", v, 32'd5);
        rd(0, v); check("oneshot_en", v, 32'h0);
        idle(10);
        rd(1, v); check("oneshot_hold", v, 32'd5);
        wr(3, 1);

        wr(1, 0); wr(2, 3); wr(0, 32'h7);
        idle(3);
        check("ar_irq", {31'd0, bif.Irq}, {31'd0, IRQ_IMPL});
        rd(1, v); check("ar_count", v, 32'h0);
        wr(3, 1);
        check("ar_irq_clr", {31'd0, bif.Irq}, 32'h0);
        rd(1, v); check("ar_running", v, 32'd2);
        wr(0, 0); wr(3, 1);

        wr(2, 7); wr(1, 0); wr(0, 32'h3);
        idle(1);
        wr(1, 32'hFFFF_FFFE);
        rd(1, v); check("wrap_written", v, 32'hFFFF_FFFE);
        idle(1);
        rd(1, v); check("wrap_zero", v, 32'h0);
        rd(3, v); check("wrap_nomatch", v, 32'h0);
        wr(1, 5); idle(1); wr(3, 1);
        rd(3, v); check("w1c_set_wins", v, 32'h1);
        wr(0, 0); wr(3, 1);

        wr(2, 2); wr(1, 0); wr(0, 32'h0000_0307);
        idle(12);
        check("pre_rst_irq", {31'd0, bif.Irq}, {31'd0, IRQ_IMPL});
        rd(0, v); check("pre_rst_ctrl", v, {24'd0, 8'h03 & 8'hFF} << 8 | {29'd0, IRQ_IMPL, 2'b11});
        #2 Reset = 1'b1;
        #1;
        check("async_rst_dout", bif.Dataout, 32'h0);
        check("async_rst_irq", {31'd0, bif.Irq}, 32'h0);
        check("async_rst_count", dut.count_q, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        rd(1, v); check("post_rst_count", v, 32'h0);

        for (int i = 0; i < 2500; i++) begin
            op = $urandom_range(0, 99);
            a  = BASE + $urandom_range(0, 15);
            if (op < 8) a = $urandom;
            w  = (op >= 78);
            d  = $urandom;
            if (w) begin
                case (a[3:2])
                    2'd0: begin
                        d[15:8] = 8'($urandom_range(0, 3));
                        d[0]    = ($urandom_range(0, 3) != 0);
                    end
                    2'd1: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                          : 32'($urandom_range(0, 12));
                    2'd2: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12));
                    default: ;
                endcase
            end
            cyc(a, w, d, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
